// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter with registered one-hot grant, encoded select and a forced
// dead cycle between grants. Define ARB_TIMEOUT_EN to build the hold-time limit.
module rr_decoder_arbiter #(
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned MAX_HOLD  = 15
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [(1<<SEL_WIDTH)-1:0]   req_in,
  input  logic                        done_in,
  output logic [(1<<SEL_WIDTH)-1:0]   grant_out,
  output logic [SEL_WIDTH-1:0]        grant_sel_out,
  output logic                        grant_valid_out,
  output logic                        timeout_out
);

  localparam int unsigned N       = 1 << SEL_WIDTH;
  localparam int unsigned CNT_W   = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // Parameter sanity check at elaboration
  if (SEL_WIDTH < 1 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("rr_decoder_arbiter: illegal SEL_WIDTH/MAX_HOLD");
  end

  logic [1:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [N-1:0]         grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic                 release_c;

  logic                 win_found;
  logic [SEL_WIDTH-1:0] win_idx;
  logic [SEL_WIDTH-1:0] scan_idx;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 hold_hit;
  assign hold_hit = (cnt_q + CNT_W'(1)) == CNT_W'(MAX_HOLD);
`endif

  // First requester at or after ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = ptr_q + SEL_WIDTH'(i);
      if (!win_found && req_in[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign release_c = done_in || !req_in[sel_q] || hold_hit;
`else
  assign release_c = done_in || !req_in[sel_q];
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d = GRANT;
          sel_d   = win_idx;
          grant_d = N'(1) << win_idx;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = GAP;
          ptr_d   = sel_q + SEL_WIDTH'(1);
          grant_d = '0;
          valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          tmo_d   = hold_hit && !done_in && req_in[sel_q];
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign grant_out       = grant_q;
  assign grant_sel_out   = sel_q;
  assign grant_valid_out = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout_out     = tmo_q;
`else
  assign timeout_out     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter (SEL_WIDTH=2, MAX_HOLD=3); timeout
// scenarios are exercised when ARB_TIMEOUT_EN is defined.
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic       tmo;

  int n_vec = 0;
  int n_err = 0;

  rr_decoder_arbiter #(.SEL_WIDTH(2), .MAX_HOLD(3)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .req_in          (req),
    .done_in         (done),
    .grant_out       (grant),
    .grant_sel_out   (sel),
    .grant_valid_out (valid),
    .timeout_out     (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] s, input logic v);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"},   32'(sel),   32'(s));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
  endtask

  logic [3:0] rr_seq [9];

  initial begin
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0000; rr_seq[2] = 4'b0010;
    rr_seq[3] = 4'b0000; rr_seq[4] = 4'b0100; rr_seq[5] = 4'b0000;
    rr_seq[6] = 4'b1000; rr_seq[7] = 4'b0000; rr_seq[8] = 4'b0001;

    rst_n = 1'b0; req = '0; done = 1'b0;
    @(negedge clk);
    tick();
    chk_grant("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.tmo", 32'(tmo), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_grant("idle0", 4'b0000, 2'd0, 1'b0);

    // Fairness: all request, owner pulses done each grant
    req = 4'b1111;
    tick();
    chk("rr0", 32'(grant), 32'(rr_seq[0]));
    for (int i = 1; i < 9; i++) begin
      done = (i % 2) == 1;
      tick();
      chk($sformatf("rr%0d", i), 32'(grant), 32'(rr_seq[i]));
    end
    done = 1'b0;
    // Owner 0 -> 1 -> 2
    done = 1'b1; tick(); done = 1'b0; tick();
    done = 1'b1; tick(); done = 1'b0; tick();
    chk_grant("own2", 4'b0100, 2'd2, 1'b1);

    // Wrap and skip: release 2 gives ptr=3, only 1 and 2 request
    req = 4'b0110; done = 1'b1;
    tick();
    chk_grant("skip.gap", 4'b0000, 2'd2, 1'b0);
    done = 1'b0;
    tick();
    chk_grant("skip.g1", 4'b0010, 2'd1, 1'b1);
    done = 1'b1; tick(); done = 1'b0;
    chk("skip.gap2", 32'(grant), 32'd0);
    tick();
    chk_grant("skip.g2", 4'b0100, 2'd2, 1'b1);

    // No preemption, then withdrawal
    req = 4'b0111;
    tick();
    chk("nopre0", 32'(grant), 32'(4'b0100));
    tick();
    chk("nopre1", 32'(grant), 32'(4'b0100));
    req = 4'b0011;
    tick();
    chk_grant("wd.gap", 4'b0000, 2'd2, 1'b0);
    tick();
    chk_grant("wd.g0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0010;
    tick();
    chk("wd.gap2", 32'(grant), 32'd0);
    tick();
    chk_grant("wd.g1", 4'b0010, 2'd1, 1'b1);

    // Idle hold: last winner index persists, done ignored
    req = 4'b0000;
    tick();
    chk_grant("idle.gap", 4'b0000, 2'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      done = (i == 5);
      tick();
      chk_grant($sformatf("idle%0d", i), 4'b0000, 2'd1, 1'b0);
    end
    done = 1'b0;

    // Async reset mid-grant
    req = 4'b0100;
    tick();
    chk_grant("pre_rst", 4'b0100, 2'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_grant("async_rst", 4'b0000, 2'd0, 1'b0);
    chk("async_rst.tmo", 32'(tmo), 32'd0);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_grant("post_rst", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    tick(); tick();
    chk_grant("idle2", 4'b0000, 2'd0, 1'b0);

    // Long hold: ptr=1, requesters 0 and 1
    req = 4'b0011;
    tick();
    chk_grant("hold.c1", 4'b0010, 2'd1, 1'b1);
`ifdef ARB_TIMEOUT_EN
    tick();
    chk("to.c2", 32'(grant), 32'(4'b0010));
    tick();
    chk("to.c3", 32'(grant), 32'(4'b0010));
    chk("to.c3.tmo", 32'(tmo), 32'd0);
    tick();
    chk_grant("to.gap", 4'b0000, 2'd1, 1'b0);
    chk("to.gap.tmo", 32'(tmo), 32'd1);
    tick();
    chk_grant("to.next", 4'b0001, 2'd0, 1'b1);
    chk("to.next.tmo", 32'(tmo), 32'd0);
    tick();
    tick();
    chk("to2.c3", 32'(grant), 32'(4'b0001));
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("to2.gap", 32'(grant), 32'd0);
    chk("to2.gap.tmo", 32'(tmo), 32'd0);
    tick();
    chk_grant("to2.next", 4'b0010, 2'd1, 1'b1);
    chk("to2.next.tmo", 32'(tmo), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("hold%0d", i), 32'(grant), 32'(4'b0010));
      chk($sformatf("hold%0d.tmo", i), 32'(tmo), 32'd0);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("hold.gap", 32'(grant), 32'd0);
    tick();
    chk_grant("hold.next", 4'b0001, 2'd0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
